// File: rtl/sr_cmd_debouncer_if.sv
// Button/command bundle between the raw push-buttons, the debouncer and the SR latch.
// master drives the buttons and observes the commands; slave is the debouncer itself.
interface sr_cmd_debouncer_if;
    logic set_btn;
    logic reset_btn;
    logic S;
    logic R;
    logic set_level;
    logic reset_level;
    logic conflict;

    modport master (
        output set_btn, reset_btn,
        input  S, R, set_level, reset_level, conflict
    );

    modport slave (
        input  set_btn, reset_btn,
        output S, R, set_level, reset_level, conflict
    );
endinterface

// File: rtl/sr_cmd_debouncer.sv
// Debounces the raw set/reset buttons and turns each accepted press into a single
// S or R command pulse; simultaneous presses are suppressed and flagged as a conflict.
module sr_cmd_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sr_cmd_debouncer_if.slave   btn_if
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel 0 is the set button, channel 1 the reset button.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_level;
    logic [1:0]       r_cand;
    logic [CNT_W-1:0] r_cnt [2];
    state_t           r_state [2];
    logic             r_s;
    logic             r_r;
    logic             r_conflict;

    assign w_raw = {btn_if.reset_btn, btn_if.set_btn};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_level    <= '0;
            r_cand     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                r_cnt[ch]   <= '0;
                r_state[ch] <= RELEASED;
            end
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_cand     <= '0;
            r_s        <= r_cand[0] & ~r_cand[1];
            r_r        <= r_cand[1] & ~r_cand[0];
            r_conflict <= r_cand[0] & r_cand[1];

            // The counter never exceeds LAST_CNT: acceptance clears it on the same edge.
            for (int ch = 0; ch < 2; ch++) begin
                unique case (r_state[ch])
                    RELEASED: begin
                        if (r_sync2[ch]) begin
                            r_cnt[ch]   <= CNT_ONE;
                            r_state[ch] <= PRESS_PEND;
                        end else begin
                            r_cnt[ch]   <= '0;
                        end
                    end
                    PRESS_PEND: begin
                        if (!r_sync2[ch]) begin
                            r_cnt[ch]   <= '0;
                            r_state[ch] <= RELEASED;
                        end else if (r_cnt[ch] == LAST_CNT) begin
                            r_cnt[ch]   <= '0;
                            r_level[ch] <= 1'b1;
                            r_cand[ch]  <= 1'b1;
                            r_state[ch] <= PRESSED;
                        end else begin
                            r_cnt[ch]   <= r_cnt[ch] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!r_sync2[ch]) begin
                            r_cnt[ch]   <= CNT_ONE;
                            r_state[ch] <= RELEASE_PEND;
                        end else begin
                            r_cnt[ch]   <= '0;
                        end
                    end
                    RELEASE_PEND: begin
                        if (r_sync2[ch]) begin
                            r_cnt[ch]   <= '0;
                            r_state[ch] <= PRESSED;
                        end else if (r_cnt[ch] == LAST_CNT) begin
                            r_cnt[ch]   <= '0;
                            r_level[ch] <= 1'b0;
                            r_state[ch] <= RELEASED;
                        end else begin
                            r_cnt[ch]   <= r_cnt[ch] + CNT_ONE;
                        end
                    end
                    default: begin
                        r_cnt[ch]   <= '0;
                        r_level[ch] <= 1'b0;
                        r_state[ch] <= RELEASED;
                    end
                endcase
            end
        end
    end

    assign btn_if.S           = r_s;
    assign btn_if.R           = r_r;
    assign btn_if.conflict    = r_conflict;
    assign btn_if.set_level   = r_level[0];
    assign btn_if.reset_level = r_level[1];

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Scoreboard bench for sr_cmd_debouncer with DEBOUNCE_CYCLES=4: expected command pulses
// are queued with their due cycle when a button edge is driven and matched by a monitor.
module tb_sr_cmd_debouncer;

    localparam int DEB     = 4;
    localparam int LATENCY = DEB + 3;

    localparam logic [2:0] KIND_NONE = 3'b000;
    localparam logic [2:0] KIND_S    = 3'b001;
    localparam logic [2:0] KIND_R    = 3'b010;
    localparam logic [2:0] KIND_CONF = 3'b100;

    typedef struct {
        int         cycle;
        logic [2:0] kind;
    } pulse_t;

    logic   clk;
    logic   rst_n;
    int     edgeCount;
    int     checkCount;
    int     errorCount;
    int     sPulses;
    pulse_t expQ[$];

    sr_cmd_debouncer_if busIf();

    sr_cmd_debouncer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edgeCount = 0;
    always @(posedge clk) edgeCount = edgeCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)",
                     tag, observed, expected, edgeCount);
        end
    endtask

    // Drive both buttons just after a falling edge and hold them for holdCycles cycles.
    // A non-zero expectKind queues the command pulse this edge should produce.
    task automatic applyStimulus(input logic setV, input logic resetV,
                                 input int holdCycles, input logic [2:0] expectKind);
        pulse_t p;
        @(negedge clk);
        #1;
        busIf.set_btn   = setV;
        busIf.reset_btn = resetV;
        if (expectKind != KIND_NONE) begin
            p.cycle = edgeCount + LATENCY;
            p.kind  = expectKind;
            expQ.push_back(p);
        end
        repeat (holdCycles - 1) @(negedge clk);
    endtask

    // Monitor: every observed pulse must match the head of the queue in kind and cycle;
    // a queued pulse whose cycle has passed unseen is reported as missed.
    always @(negedge clk) begin
        logic [2:0] obs;
        pulse_t     p;
        obs = {busIf.conflict, busIf.R, busIf.S};
        if (obs == KIND_S) sPulses = sPulses + 1;
        if (obs != KIND_NONE) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPulse", 32'(obs), 32'(KIND_NONE));
            end else begin
                p = expQ.pop_front();
                checkOutput("pulseKind", 32'(obs), 32'(p.kind));
                checkOutput("pulseCycle", 32'(edgeCount), 32'(p.cycle));
            end
        end else if (expQ.size() > 0 && expQ[0].cycle < edgeCount) begin
            p = expQ.pop_front();
            checkOutput("missedPulse", 32'(edgeCount), 32'(p.cycle));
        end
    end

    initial begin
        int sBefore;
        pulse_t p;
        checkCount      = 0;
        errorCount      = 0;
        sPulses         = 0;
        rst_n           = 1'b0;
        busIf.set_btn   = 1'b0;
        busIf.reset_btn = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstS", 32'(busIf.S), 0);
        checkOutput("rstR", 32'(busIf.R), 0);
        checkOutput("rstConflict", 32'(busIf.conflict), 0);
        checkOutput("rstSetLevel", 32'(busIf.set_level), 0);
        checkOutput("rstResetLevel", 32'(busIf.reset_level), 0);
        #1;
        rst_n = 1'b1;

        // Clean set press held 20 cycles.
        applyStimulus(1'b1, 1'b0, 20, KIND_S);
        checkOutput("pressSetLevel", 32'(busIf.set_level), 1);
        checkOutput("pressResetLevel", 32'(busIf.reset_level), 0);
        applyStimulus(1'b0, 1'b0, 12, KIND_NONE);
        checkOutput("releaseSetLevel", 32'(busIf.set_level), 0);
        checkOutput("queueAfterPress", 32'(expQ.size()), 0);

        // Bouncing reset button, then stable high.
        applyStimulus(1'b0, 1'b1, 1, KIND_NONE);
        applyStimulus(1'b0, 1'b0, 1, KIND_NONE);
        applyStimulus(1'b0, 1'b1, 1, KIND_NONE);
        applyStimulus(1'b0, 1'b1, 1, KIND_NONE);
        applyStimulus(1'b0, 1'b0, 1, KIND_NONE);
        applyStimulus(1'b0, 1'b1, 20, KIND_R);
        checkOutput("bounceResetLevel", 32'(busIf.reset_level), 1);
        applyStimulus(1'b0, 1'b0, 12, KIND_NONE);
        checkOutput("queueAfterBounce", 32'(expQ.size()), 0);

        // Three-cycle glitch must never reach the debounced level.
        applyStimulus(1'b1, 1'b0, 3, KIND_NONE);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1, KIND_NONE);
            checkOutput("glitchSetLevel", 32'(busIf.set_level), 0);
        end

        // Simultaneous press: conflict instead of S/R.
        applyStimulus(1'b1, 1'b1, 10, KIND_CONF);
        checkOutput("confSetLevel", 32'(busIf.set_level), 1);
        checkOutput("confResetLevel", 32'(busIf.reset_level), 1);
        applyStimulus(1'b0, 1'b0, 12, KIND_NONE);
        checkOutput("queueAfterConflict", 32'(expQ.size()), 0);

        // Reset during PRESS_PEND with the button held: fresh press after release of reset.
        applyStimulus(1'b1, 1'b0, 3, KIND_NONE);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midResetSetLevel", 32'(busIf.set_level), 0);
        checkOutput("midResetS", 32'(busIf.S), 0);
        #1;
        rst_n   = 1'b1;
        p.cycle = edgeCount + LATENCY;
        p.kind  = KIND_S;
        expQ.push_back(p);
        repeat (15) @(negedge clk);
        checkOutput("afterResetSetLevel", 32'(busIf.set_level), 1);
        applyStimulus(1'b0, 1'b0, 12, KIND_NONE);
        checkOutput("queueAfterReset", 32'(expQ.size()), 0);

        // Press, accepted release, press again: exactly two S pulses.
        sBefore = sPulses;
        applyStimulus(1'b1, 1'b0, 12, KIND_S);
        applyStimulus(1'b0, 1'b0, 12, KIND_NONE);
        checkOutput("repressReleased", 32'(busIf.set_level), 0);
        applyStimulus(1'b1, 1'b0, 12, KIND_S);
        applyStimulus(1'b0, 1'b0, 12, KIND_NONE);
        checkOutput("repressCount", 32'(sPulses - sBefore), 2);
        checkOutput("queueFinal", 32'(expQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
